mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-access stage load/store unit between the EX/MEM and MEM/WB pipeline registers. It takes a decoded load or store from EX/MEM and runs a request/grant/response handshake with data memory. It performs byte-lane alignment, store-data replication and load sign/zero extension. It freezes the pipeline with `stall_out` until the access completes, and presents the extended load value as `ram_output_out` for the MEM/WB register.

## Interface
- `MAX_WAIT`, 255: cycles allowed in REQ+WAIT before timeout abort; range 1..65535.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  active-low asynchronous reset; one clock; all state cleared on assertion.
- `ex_valid_in`  in  1  EX/MEM holds a valid instruction.
- `mem_read_in`  in  1  instruction is a load.
- `mem_write_in`  in  1  instruction is a store.
- `funct3_in`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- `addr_in`  in  32  effective address (ALU result).
- `store_data_in`  in  32  rs2 value.
- `dmem_req_out`  out  1  request valid.
- `dmem_we_out`  out  1  1 = write.
- `dmem_addr_out`  out  32  word address, `{addr[31:2],2'b00}`.
- `dmem_be_out`  out  4  byte enables.
- `dmem_wdata_out`  out  32  lane-replicated store data.
- `dmem_gnt_in`  in  1  request accepted this cycle.
- `dmem_rvalid_in`  in  1  read data valid.
- `dmem_rdata_in`  in  32  read word.
- `ram_output_out`  out  32  extended load result, registered.
- `stall_out`  out  1  hold EX/MEM and PC, disable MEM/WB.
- `error_out`  out  1  one-cycle pulse: misaligned, illegal funct3, read&write both set, or timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - Access = `ex_valid_in & (mem_read_in | mem_write_in)`.
  - Legal access: latch the address offset, funct3, we, be and wdata, then go to REQ. `stall_out`=1 combinationally in the same cycle.
  - Illegal access: no request, `stall_out`=0, `error_out`=1 combinationally, remain in IDLE.
  - No access: `stall_out`=0.
- REQ:
  - `dmem_req_out`=1 and `stall_out`=1.
  - Address, be, we and wdata are driven from the latched registers and held stable until `dmem_gnt_in`.
  - On gnt: write → DONE; read → WAIT.
- WAIT:
  - `stall_out`=1.
  - On `dmem_rvalid_in`: `ram_output_out` ← extend(`dmem_rdata_in >> 8*off`), then go to DONE.
- DONE:
  - `stall_out`=0 for exactly one cycle, so the pipeline advances.
  - No new access is started in DONE, even if the inputs show one.
  - Then go to IDLE.
- Alignment rules:
  - H/HU/SH require `addr[0]`=0.
  - W/SW require `addr[1:0]`=0.
  - Loads with funct3 011/110/111 are illegal. Stores with funct3 other than 000/001/010 are illegal.
- Byte enables:
  - SB: `4'b0001<<off`.
  - SH: `4'b0011<<off`.
  - SW: `4'b1111`.
  - Loads: `4'b1111`.
- Store data: SB `{4{d[7:0]}}`, SH `{2{d[15:0]}}`, SW `d`.
- Load extension: B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through.
- Timeout:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `MAX_WAIT`: pulse `error_out`, leave `ram_output_out`=0 for a load, go to DONE, drop `dmem_req_out`.
- `ram_output_out` holds its value except on a rvalid capture or a load timeout.

## Timing
- Reset values: `dmem_req_out`=0, `dmem_we_out`=0, `dmem_addr_out`=0, `dmem_be_out`=0, `dmem_wdata_out`=0, `ram_output_out`=0, `stall_out`=0, `error_out`=0.
- Reset assertion mid-access drops `dmem_req_out` immediately (async) and returns the FSM to IDLE. Any outstanding response after reset release is ignored.
- Minimum latency, measured from the cycle the access is presented:
  - Store with gnt on the first REQ cycle: stall for 2 cycles, DONE on cycle 2.
  - Load with gnt in REQ and rvalid on the next cycle: stall for 3 cycles, DONE on cycle 3. `ram_output_out` is valid from DONE onward.
- `dmem_rvalid_in` asserted while in REQ or IDLE is ignored. rvalid is accepted only in WAIT.
- `dmem_gnt_in` outside REQ is ignored.
- `error_out` is never asserted together with `dmem_req_out` rising.

## Test plan
- LW at `0x100`, gnt immediate, rdata `0xDEADBEEF` → `stall_out`=1 for 3 cycles, `ram_output_out`=`0xDEADBEEF`, one DONE cycle.
- LB at `0x103`, rdata `0x80FF_1234` → `ram_output_out`=`0xFFFFFF80`. LBU at the same address → `0x00000080`. LHU at `0x102` → `0x000080FF`.
- SH at `0x202`, data `0x0000ABCD`, gnt delayed 3 cycles → `dmem_be_out`=`1100`, `dmem_wdata_out`=`0xABCDABCD`, request held stable for 4 cycles, `stall_out`=1 for 5 cycles.
- LW at `0x101`; then SH at `0x203` → `error_out` pulse, no `dmem_req_out`, `stall_out`=0 for each.
- `MAX_WAIT`=4, load granted but rvalid never arrives → `error_out` after 4 cycles, `ram_output_out`=0, FSM passes through DONE to IDLE.
- Reset asserted during WAIT, rvalid arriving after reset release → outputs at reset values, rvalid ignored. A following LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one outstanding data-memory access with a request/grant/response
// handshake, byte-lane alignment, store-data replication and load extension.
module mem_stage_lsu #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   output logic        dmem_req_out,
   output logic        dmem_we_out,
   output logic [31:0] dmem_addr_out,
   output logic [3:0]  dmem_be_out,
   output logic [31:0] dmem_wdata_out,
   input  logic        dmem_gnt_in,
   input  logic        dmem_rvalid_in,
   input  logic [31:0] dmem_rdata_in,
   output logic [31:0] ram_output_out,
   output logic        stall_out,
   output logic        error_out
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [15:0] cnt;
   logic        err_q;

   logic        access;
   logic        f3_ok;
   logic        align_ok;
   logic        legal;
   logic        timeout;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] shifted;
   logic [31:0] load_ext;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      f3_ok    = 1'b0;
      align_ok = 1'b0;
      be_n     = 4'b1111;
      wdata_n  = '0;
      access   = ex_valid_in & (mem_read_in | mem_write_in);

      case (funct3_in)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = mem_read_in;
         default:                f3_ok = 1'b0;
      endcase

      case (funct3_in[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~addr_in[0];
         2'b10:   align_ok = (addr_in[1:0] == 2'b00);
         default: align_ok = 1'b0;
      endcase

      legal = f3_ok & align_ok & ~(mem_read_in & mem_write_in);

      if (mem_write_in) begin
         case (funct3_in[1:0])
            2'b00: begin
               be_n    = 4'b0001 << addr_in[1:0];
               wdata_n = {4{store_data_in[7:0]}};
            end
            2'b01: begin
               be_n    = 4'b0011 << addr_in[1:0];
               wdata_n = {2{store_data_in[15:0]}};
            end
            default: begin
               be_n    = 4'b1111;
               wdata_n = store_data_in;
            end
         endcase
      end
   end

   // Bring the addressed lane down to bit 0, then extend by the latched access width.
   always_comb begin
      shifted = dmem_rdata_in >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   assign timeout   = (cnt == 16'(MAX_WAIT - 1));
   assign stall_out = (state == S_IDLE && access && legal) || state == S_REQ || state == S_WAIT;
   assign error_out = (state == S_IDLE && access && !legal) || err_q;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         off_q          <= '0;
         f3_q           <= '0;
         cnt            <= '0;
         err_q          <= 1'b0;
         dmem_req_out   <= 1'b0;
         dmem_we_out    <= 1'b0;
         dmem_addr_out  <= '0;
         dmem_be_out    <= '0;
         dmem_wdata_out <= '0;
         ram_output_out <= '0;
      end else begin
         err_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (access && legal) begin
                  off_q          <= addr_in[1:0];
                  f3_q           <= funct3_in;
                  dmem_we_out    <= mem_write_in;
                  dmem_addr_out  <= {addr_in[31:2], 2'b00};
                  dmem_be_out    <= be_n;
                  dmem_wdata_out <= wdata_n;
                  dmem_req_out   <= 1'b1;
                  cnt            <= '0;
                  state          <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_gnt_in && dmem_we_out) begin
                  dmem_req_out <= 1'b0;
                  state        <= S_DONE;
               end else if (timeout) begin
                  dmem_req_out <= 1'b0;
                  err_q        <= 1'b1;
                  if (!dmem_we_out) ram_output_out <= '0;
                  state        <= S_DONE;
               end else if (dmem_gnt_in) begin
                  dmem_req_out <= 1'b0;
                  cnt          <= cnt + 16'd1;
                  state        <= S_WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_WAIT: begin
               if (dmem_rvalid_in) begin
                  ram_output_out <= load_ext;
                  state          <= S_DONE;
               end else if (timeout) begin
                  ram_output_out <= '0;
                  err_q          <= 1'b1;
                  state          <= S_DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
